// File: rtl/congestion_estimator.sv
// Windowed vehicle-event counter with EMA smoothing and a hysteretic, rate-limited 2-bit level.
// Optional stuck-detector supervision is built when CONGESTION_STUCK_DETECT_EN is defined.
module congestion_estimator #(
    parameter int WINDOW_TICKS = 100,
    parameter int CNT_W        = 8,
    parameter int EMA_SHIFT    = 2,
    parameter int TH1          = 4,
    parameter int TH2          = 10,
    parameter int TH3          = 20,
    parameter int HYST         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             det_ns,
    input  logic             det_ew,
    output logic [1:0]       congestion_level,
    output logic             level_valid,
    output logic             window_done,
    output logic [CNT_W-1:0] raw_count,
    output logic [CNT_W-1:0] avg_count,
    output logic             det_fault
);
    localparam int TW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam logic [CNT_W-1:0] TH1_V = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] TH2_V = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] TH3_V = CNT_W'(TH3);
    localparam logic [CNT_W-1:0] DN1_V = CNT_W'(TH1 - HYST);
    localparam logic [CNT_W-1:0] DN2_V = CNT_W'(TH2 - HYST);
    localparam logic [CNT_W-1:0] DN3_V = CNT_W'(TH3 - HYST);

    typedef enum logic [1:0] {S_COUNT, S_AVG, S_QUANT} state_t;
    state_t state, state_nxt;

    logic [TW-1:0]    tick_cnt;
    logic             close;
    logic [1:0]       det, det_q, rise, fault;
    logic [CNT_W-1:0] acc, acc_sum;
    logic [CNT_W:0]   acc_ext;
    logic             seeded;

    assign det         = {det_ew, det_ns};
    assign close       = tick && (tick_cnt == TW'(WINDOW_TICKS - 1));
    assign window_done = close;
    assign rise        = det & ~det_q & ~fault;
    assign det_fault   = |fault;

`ifdef CONGESTION_STUCK_DETECT_EN
    localparam int SW = $clog2(2 * WINDOW_TICKS + 1);
    localparam logic [SW-1:0] STUCK_LIM = SW'(2 * WINDOW_TICKS);

    // Per lane: ticks spent continuously high; a low level rearms the lane.
    for (genvar l = 0; l < 2; l++) begin : g_stuck
        logic [SW-1:0] stuck;
        assign fault[l] = (stuck == STUCK_LIM);
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                       stuck <= '0;
            else if (!det[l])              stuck <= '0;
            else if (tick && !fault[l])    stuck <= stuck + 1'b1;
        end
    end
`else
    assign fault = 2'b00;
`endif

    // Saturating accumulate: up to two events per cycle.
    assign acc_ext = {1'b0, acc} + (CNT_W+1)'(rise[0]) + (CNT_W+1)'(rise[1]);
    assign acc_sum = acc_ext[CNT_W] ? '1 : acc_ext[CNT_W-1:0];

    // EMA step in signed CNT_W+1 arithmetic, result clamped to the unsigned range.
    logic signed [CNT_W:0]   diff, step;
    logic signed [CNT_W+1:0] ema_sum;
    logic [CNT_W-1:0]        ema;

    always_comb begin
        diff    = $signed({1'b0, raw_count}) - $signed({1'b0, avg_count});
        step    = diff >>> EMA_SHIFT;
        ema_sum = $signed({2'b00, avg_count}) + $signed({step[CNT_W], step});
        if (ema_sum[CNT_W+1])  ema = '0;
        else if (ema_sum[CNT_W]) ema = '1;
        else                   ema = ema_sum[CNT_W-1:0];
    end

    logic [1:0]       target, level_nxt;
    logic [CNT_W-1:0] down_th;

    always_comb begin
        if (avg_count >= TH3_V)      target = 2'd3;
        else if (avg_count >= TH2_V) target = 2'd2;
        else if (avg_count >= TH1_V) target = 2'd1;
        else                         target = 2'd0;
        case (congestion_level)
            2'd1:    down_th = DN1_V;
            2'd2:    down_th = DN2_V;
            2'd3:    down_th = DN3_V;
            default: down_th = '0;
        endcase
        level_nxt = congestion_level;
        if (target > congestion_level)
            level_nxt = congestion_level + 2'd1;
        else if (target < congestion_level && avg_count < down_th)
            level_nxt = congestion_level - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COUNT: if (close) state_nxt = S_AVG;
            S_AVG:   state_nxt = S_QUANT;
            S_QUANT: state_nxt = S_COUNT;
            default: state_nxt = S_COUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_COUNT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt         <= '0;
            det_q            <= '0;
            acc              <= '0;
            raw_count        <= '0;
            avg_count        <= '0;
            seeded           <= 1'b0;
            congestion_level <= '0;
            level_valid      <= 1'b0;
        end else begin
            det_q       <= det;
            level_valid <= (state == S_QUANT);
            if (close) begin
                tick_cnt  <= '0;
                acc       <= '0;
                raw_count <= acc_sum;
            end else begin
                if (tick) tick_cnt <= tick_cnt + 1'b1;
                acc <= acc_sum;
            end
            if (state == S_AVG) begin
                avg_count <= seeded ? ema : raw_count;
                seeded    <= 1'b1;
            end
            if (state == S_QUANT) congestion_level <= level_nxt;
        end
    end
endmodule

// File: tb/tb_congestion_estimator.sv
// Directed bench for congestion_estimator: idle, ramp, hysteresis, saturation, boundary, reset, stuck lane.
module tb_congestion_estimator;
    localparam int WT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       det_ns = 1'b0;
    logic       det_ew = 1'b0;
    logic [1:0] congestion_level;
    logic       level_valid, window_done, det_fault;
    logic [7:0] raw_count, avg_count;

    int n_checks = 0;
    int n_errors = 0;

`ifdef CONGESTION_STUCK_DETECT_EN
    localparam int FAULT_EXP = 1;
`else
    localparam int FAULT_EXP = 0;
`endif

    congestion_estimator dut (
        .clk(clk), .rst(rst), .tick(tick), .det_ns(det_ns), .det_ew(det_ew),
        .congestion_level(congestion_level), .level_valid(level_valid),
        .window_done(window_done), .raw_count(raw_count), .avg_count(avg_count),
        .det_fault(det_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick = 1'b0; det_ns = 1'b0; det_ew = 1'b0;
        #1;
        check("rst_raw", raw_count, 0);
        check("rst_avg", avg_count, 0);
        check("rst_level", congestion_level, 0);
        check("rst_valid", level_valid, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full window (5 cycles per tick); detector patterns are laid out from cycle 0.
    task automatic run_window(input string tag, input int ns_n, input int both_n,
                              input bit close_edge, input bit hold,
                              input int e_raw, input int e_avg, input int e_lvl);
        for (int c = 0; c < 5 * WT; c++) begin
            @(negedge clk);
            tick   = (c % 5 == 4);
            det_ns = hold || ((c < 2 * ns_n) && (c % 2 == 0)) || ((c < 2 * both_n) && (c % 2 == 0));
            det_ew = (c < 2 * both_n) && (c % 2 == 0);
            if (close_edge && c == 5 * WT - 1) det_ns = 1'b1;
            #1;
            if (c == 5 * WT - 1)      check({tag, "_wdone"}, window_done, 1);
            else if (c == 5 * WT - 2) check({tag, "_wdone_pre"}, window_done, 0);
        end
        @(posedge clk); #1;
        tick = 1'b0; det_ew = 1'b0;
        if (!hold) det_ns = 1'b0;
        check({tag, "_raw"}, raw_count, e_raw);
        check({tag, "_valid_n1"}, level_valid, 0);
        @(posedge clk); #1;
        check({tag, "_avg"}, avg_count, e_avg);
        check({tag, "_valid_n2"}, level_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid_n3"}, level_valid, 1);
        check({tag, "_level"}, congestion_level, e_lvl);
        @(posedge clk); #1;
        check({tag, "_valid_n4"}, level_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        check("init_fault", det_fault, 0);
        check("init_wdone", window_done, 0);
        do_reset();

        // Idle windows
        run_window("idle1", 0, 0, 0, 0, 0, 0, 0);
        run_window("idle2", 0, 0, 0, 0, 0, 0, 0);
        run_window("idle3", 0, 0, 0, 0, 0, 0, 0);

        // Ramp from a fresh seed: level climbs one step per window
        do_reset();
        run_window("ramp1", 25, 0, 0, 0, 25, 25, 1);
        run_window("ramp2", 25, 0, 0, 0, 25, 25, 2);
        run_window("ramp3", 25, 0, 0, 0, 25, 25, 3);

        // Decay with hysteresis on the way down
        run_window("down1", 0, 0, 0, 0, 0, 18, 3);
        run_window("down2", 0, 0, 0, 0, 0, 13, 2);
        run_window("down3", 0, 0, 0, 0, 0, 9, 2);
        run_window("down4", 0, 0, 0, 0, 0, 6, 1);

        // 400 simultaneous events saturate; avg 6 + floor(249/4) = 68
        run_window("sat", 0, 200, 0, 0, 255, 68, 2);

        // Edge in the close cycle belongs to the closing window
        run_window("bnd", 5, 0, 1, 0, 6, 52, 3);
        run_window("bnd_next", 0, 0, 0, 0, 0, 39, 3);

        // Mid-window reset, then re-seed
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            tick   = (c % 5 == 4);
            det_ns = (c % 2 == 0);
        end
        do_reset();
        run_window("reseed", 12, 0, 0, 0, 12, 12, 1);

        // NS held high for 200 ticks
        run_window("hold1", 0, 0, 0, 1, 1, 9, 1);
        run_window("hold2", 0, 0, 0, 1, 0, 6, 1);
        check("stuck_fault", det_fault, FAULT_EXP);
        @(negedge clk);
        det_ns = 1'b0;
        @(posedge clk); #1;
        check("stuck_clear", det_fault, 0);
        run_window("resume", 3, 0, 0, 0, 3, 5, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/congestion_estimator.md
Name: congestion_estimator

Overview:
- Upstream feeder of the traffic phase controller; produces its `congestion_level` input.
- Counts vehicle-detector events from the NS and EW approaches over a fixed tick window.
- Smooths the windowed count with a shift-based EMA, then quantises it to a 2-bit level using thresholds, hysteresis and one-step-per-window rate limiting.
- Issues a one-cycle `level_valid` strobe with each new level.

Parameters:
- WINDOW_TICKS, 100: tick strobes per counting window (1 tick = 10 ms, so 1 s window).
- CNT_W, 8: width of count and average registers; counts saturate at 2^CNT_W-1.
- EMA_SHIFT, 2: smoothing factor, alpha = 1/2^EMA_SHIFT.
- TH1, 4: minimum average for level 1.
- TH2, 10: minimum average for level 2.
- TH3, 20: minimum average for level 3.
- HYST, 2: down-step margin. Constraint: HYST < TH1 < TH2 < TH3 < 2^CNT_W.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- tick, in, 1: one-cycle time-base strobe.
- det_ns, in, 1: NS loop detector level, already synchronous to clk.
- det_ew, in, 1: EW loop detector level, already synchronous to clk.
- congestion_level, out, 2: quantised level 0..3, held between updates.
- level_valid, out, 1: one-cycle pulse when congestion_level is (re)written.
- window_done, out, 1: one-cycle pulse on the window-close cycle.
- raw_count, out, CNT_W: event count of the last closed window.
- avg_count, out, CNT_W: EMA value.
- det_fault, out, 1: stuck-detector flag; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high): all outputs, counters, edge-detect history and FSM state clear to 0 / S_COUNT. A reset mid-window discards the partial count. The first closed window after reset is the seed window.
- Event detection: a rising edge on det_ns or det_ew (registered previous value) is one event. Edges on both inputs in the same cycle add 2. The accumulator saturates at 2^CNT_W-1 and never wraps.
- Window: a tick counter advances on `tick`. The cycle where tick=1 and the counter = WINDOW_TICKS-1 is the close cycle N:
  - window_done=1 at N.
  - Events in cycle N belong to the closing window.
  - The accumulator restarts at 0 at N+1.
  - The tick counter wraps to 0.
- FSM S_COUNT -> S_AVG -> S_QUANT -> S_COUNT:
  - S_COUNT leaves on the close cycle N.
  - S_AVG and S_QUANT are single cycles.
  - Event counting continues in every state.
  - A window close cannot collide with S_AVG/S_QUANT when WINDOW_TICKS >= 1, because tick spacing exceeds 2 cycles.
- Latency:
  - raw_count updates at N+1.
  - avg_count updates at N+2.
  - congestion_level updates and level_valid pulses at N+3.
  - level_valid pulses every window, even when the level is unchanged.
- EMA, computed in S_AVG:
  - Seed window: avg = raw.
  - Otherwise: avg = avg + ((raw - avg) >>> EMA_SHIFT), using signed CNT_W+1 arithmetic.
  - The arithmetic shift floors toward -infinity.
  - The result is clamped to [0, 2^CNT_W-1].
- Quantise, computed in S_QUANT:
  - target = 3 if avg>=TH3, 2 if avg>=TH2, 1 if avg>=TH1, else 0.
  - Up step: if target > level, level+1.
  - Down step: if target < level and avg < TH[level] - HYST, level-1.
  - Otherwise the level holds.
  - The level changes by at most one step per window.

Optional Feature:
- Macro: CONGESTION_STUCK_DETECT_EN.
- When defined:
  - Per lane, a counter counts ticks while the detector stays continuously high.
  - Reaching 2*WINDOW_TICKS asserts det_fault, and that lane's events are ignored.
  - The lane's fault clears on its next low level, and events resume on the next rising edge.
  - det_fault is the OR of both lanes.
- When undefined: det_fault is tied to 0 and no stuck counters are built.

Test Plan:
- Idle: no detector edges for 3 windows -> raw_count=0, avg_count=0, congestion_level=0; level_valid pulses 3 times, each 3 cycles after window_done.
- Ramp up: 25 NS edges per window for 3 windows -> raw=25 and avg=25 after the seed; levels 1, 2, 3 in successive windows (rate limited).
- Hysteresis down: from avg=25/level 3, apply 0 events per window:
  - Window 1: avg 18 -> level 3 (18 is not < 20-2).
  - Window 2: avg 13 -> level 2.
  - Window 3: avg 9 -> level 2 (9 is not < 10-2).
  - Window 4: avg 6 -> level 1.
- Simultaneous/saturation: det_ns and det_ew rise in the same cycle 200 times in one window -> raw_count=255 (saturated, no wrap).
- Boundary and reset:
  - An edge in close cycle N is counted in raw_count at N+1, not in the next window.
  - Asserting rst mid-window clears all outputs immediately, and the next window re-seeds the EMA.
- Stuck detector (macro defined): det_ns held high 200 ticks -> det_fault=1 and NS edges ignored; det_ns low -> det_fault=0, and counting resumes on the next rising edge.
